// File: rtl/shot.sv
// Shot clock: a rising edge on shoot starts a START..0 countdown (one step per
// TICK_DIV cycles); at expiry buzz is held for BUZZ_LEN cycles, then back to idle.
module shot #(
  parameter int START    = 9,
  parameter int TICK_DIV = 1,
  parameter int BUZZ_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shoot,
  output logic [3:0] count,
  output logic       buzz
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BUZZ_LEN > 1) ? $clog2(BUZZ_LEN) : 1;
  localparam logic [PW-1:0] PMAX    = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BMAX    = BW'(BUZZ_LEN - 1);
  localparam logic [3:0]    START_V = 4'(START);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t        state, state_d;
  logic          shoot_q, armed, shoot_rise, go, tick;
  logic [PW-1:0] presc, presc_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [3:0]    count_d;
  logic          buzz_d;

  assign shoot_rise = shoot & ~shoot_q;
  // shoot_q restarts at 0 after reset, so a level still high at release would
  // look like a new edge; armed blocks that until shoot has been seen low.
  assign go   = shoot_rise & armed;
  assign tick = (presc == PMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shoot_q <= 1'b0;
      armed   <= 1'b0;
      presc   <= '0;
      bcnt    <= '0;
      count   <= START_V;
      buzz    <= 1'b0;
    end else begin
      state   <= state_d;
      shoot_q <= shoot;
      armed   <= armed | ~shoot;
      presc   <= presc_d;
      bcnt    <= bcnt_d;
      count   <= count_d;
      buzz    <= buzz_d;
    end
  end

  always_comb begin
    state_d = state;
    presc_d = presc;
    bcnt_d  = bcnt;
    count_d = count;
    buzz_d  = buzz;
    unique case (state)
      IDLE: begin
        count_d = START_V;
        buzz_d  = 1'b0;
        if (go) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        buzz_d = 1'b0;
        if (go) begin
          count_d = START_V;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (count <= 4'd1) begin
            state_d = EXPIRED;
            count_d = 4'd0;
            buzz_d  = 1'b1;
            bcnt_d  = '0;
          end else begin
            count_d = count - 4'd1;
          end
        end else begin
          presc_d = presc + PW'(1);
        end
      end
      EXPIRED: begin
        count_d = 4'd0;
        buzz_d  = 1'b1;
        if (go) begin
          state_d = RUN;
          count_d = START_V;
          buzz_d  = 1'b0;
          presc_d = '0;
          bcnt_d  = '0;
        end else if (bcnt == BMAX) begin
          state_d = IDLE;
          count_d = START_V;
          buzz_d  = 1'b0;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = START_V;
        buzz_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shot.sv
// Scoreboard bench for shot: default instance plus a START=2 / TICK_DIV=3 instance.
module tb_shot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       shoot = 1'b0;
  logic       shoot2 = 1'b0;
  logic [3:0] count, count2;
  logic       buzz, buzz2;

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] sb_q[$];

  shot dut (
    .clk  (clk),
    .rst_n(rst_n),
    .shoot(shoot),
    .count(count),
    .buzz (buzz)
  );

  shot #(.START(2), .TICK_DIV(3), .BUZZ_LEN(4)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .shoot(shoot2),
    .count(count2),
    .buzz (buzz2)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ev(input int c, input bit b);
    return {4'(c), b};
  endfunction

  task automatic test_reset();
    logic [4:0] got, exp;
    rst_n = 1'b0; shoot = 1'b0; shoot2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      sb_q.push_back(ev(9, 1'b0));
      sb_q.push_back(ev(2, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
      exp = sb_q.pop_front(); got = {count2, buzz2}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_div[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_countdown();
    logic [4:0] got, exp;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      shoot = (i < 4);
      if (i == 0)       sb_q.push_back(ev(9, 1'b0));
      else if (i <= 8)  sb_q.push_back(ev(9 - i, 1'b0));
      else if (i <= 12) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL countdown[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_restart_run();
    logic [4:0] got, exp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      shoot = (i == 0 || i == 6);
      if (i <= 5)       sb_q.push_back(ev(9 - i, 1'b0));
      else if (i <= 14) sb_q.push_back(ev(15 - i, 1'b0));
      else if (i <= 18) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL restart_run[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_restart_buzz();
    logic [4:0] got, exp;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      shoot = (i == 0 || i == 11);
      if (i <= 8)       sb_q.push_back(ev(9 - i, 1'b0));
      else if (i <= 10) sb_q.push_back(ev(0, 1'b1));
      else if (i <= 19) sb_q.push_back(ev(20 - i, 1'b0));
      else if (i <= 23) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL restart_buzz[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] got, exp;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      shoot = (i == 0 || i == 11);
      rst_n = (i != 5);
      if (i <= 4)       sb_q.push_back(ev(9 - i, 1'b0));
      else if (i <= 11) sb_q.push_back(ev(9, 1'b0));
      else if (i <= 19) sb_q.push_back(ev(20 - i, 1'b0));
      else if (i <= 23) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_run[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_held_at_release();
    logic [4:0] got, exp;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n = (i != 0);
      shoot = (i <= 4 || i == 6);
      if (i <= 6)       sb_q.push_back(ev(9, 1'b0));
      else if (i <= 14) sb_q.push_back(ev(15 - i, 1'b0));
      else if (i <= 18) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL held_at_release[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_held_high();
    logic [4:0] got, exp;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      shoot = (i < 100);
      if (i <= 8)       sb_q.push_back(ev(9 - i, 1'b0));
      else if (i <= 12) sb_q.push_back(ev(0, 1'b1));
      else              sb_q.push_back(ev(9, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count, buzz}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL held_high[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  task automatic test_tick_div();
    logic [4:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      shoot2 = (i == 0);
      if (i <= 2)      sb_q.push_back(ev(2, 1'b0));
      else if (i <= 5) sb_q.push_back(ev(1, 1'b0));
      else if (i <= 9) sb_q.push_back(ev(0, 1'b1));
      else             sb_q.push_back(ev(2, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front(); got = {count2, buzz2}; n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL tick_div[%0d]: got count=%0d buzz=%b, expected count=%0d buzz=%b", i, got[4:1], got[0], exp[4:1], exp[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_countdown();
    test_restart_run();
    test_restart_buzz();
    test_reset_mid_run();
    test_held_at_release();
    test_held_high();
    test_tick_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
